// File: rtl/delta_scheduler_if.sv
// rtl/delta_scheduler_if.sv - Frame input / spike event output bundle for delta_scheduler
interface delta_scheduler_if #(
  parameter int NUM_CH = 4,
  parameter int DW     = 4
);
  localparam int CW = $clog2(NUM_CH);

  logic                 in_valid;
  logic                 in_ready;
  logic [NUM_CH*DW-1:0] in_data;
  logic [DW-1:0]        threshold;
  logic                 off_spike_en;
  logic                 ev_valid;
  logic                 ev_ready;
  logic [CW-1:0]        ev_ch;
  logic                 ev_pol;
  logic [7:0]           ev_ts;
  logic                 overflow;
  logic                 ovf_clr;
  logic                 busy;

  modport slave (
    input  in_valid, in_data, threshold, off_spike_en, ev_ready, ovf_clr,
    output in_ready, ev_valid, ev_ch, ev_pol, ev_ts, overflow, busy
  );

  modport master (
    output in_valid, in_data, threshold, off_spike_en, ev_ready, ovf_clr,
    input  in_ready, ev_valid, ev_ch, ev_pol, ev_ts, overflow, busy
  );
endinterface

// File: rtl/delta_scheduler.sv
// rtl/delta_scheduler.sv - Per-channel delta-modulation scan feeding a show-ahead spike event FIFO
// Define DELTA_SCHED_TIMESTAMP_EN to tag each event with the 8-bit frame counter on ev_ts.
module delta_scheduler #(
  parameter int NUM_CH     = 4,
  parameter int DW         = 4,
  parameter int FIFO_DEPTH = 4
) (
  input logic              clk,
  input logic              rst_n,
  delta_scheduler_if.slave bus
);
  localparam int CW = $clog2(NUM_CH);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST_CH  = CW'(NUM_CH - 1);
  localparam logic [AW:0]   FULL_CNT = FIFO_DEPTH[AW:0];

  typedef enum logic {IDLE, SCAN} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        ch_q;
  logic [NUM_CH*DW-1:0] data_q;
  logic [DW-1:0]        thr_q;
  logic                 off_en_q;
  logic [DW-1:0]        prev_q [NUM_CH];
  logic                 overflow_q;
  logic                 in_ready_c, busy_c, accept;

  logic [CW-1:0]        mem_ch  [FIFO_DEPTH];
  logic                 mem_pol [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [AW:0]          count;
  logic                 fifo_empty, fifo_full, push, pop, drop;

  logic [DW-1:0]        cur_s, prev_s;
  logic signed [DW+1:0] diff, thr_s;
  logic                 is_on, is_off, spike;

  always_comb begin
    state_d    = state_q;
    in_ready_c = 1'b0;
    busy_c     = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) state_d = SCAN;
      end
      SCAN: begin
        busy_c = 1'b1;
        if (ch_q == LAST_CH) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept = bus.in_valid && in_ready_c;

  // Two guard bits keep both the difference and the negated threshold exact.
  assign cur_s  = data_q[int'(ch_q)*DW +: DW];
  assign prev_s = prev_q[ch_q];
  assign diff   = $signed({2'b00, cur_s}) - $signed({2'b00, prev_s});
  assign thr_s  = $signed({2'b00, thr_q});
  assign is_on  = diff > thr_s;
  assign is_off = off_en_q && (diff < -thr_s);
  assign spike  = busy_c && (is_on || is_off);

  // A pop in the same cycle frees the slot, so a full FIFO only drops without one.
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_CNT);
  assign pop        = !fifo_empty && bus.ev_ready;
  assign push       = spike && (!fifo_full || pop);
  assign drop       = spike && fifo_full && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ch_q       <= '0;
      data_q     <= '0;
      thr_q      <= '0;
      off_en_q   <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      overflow_q <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) prev_q[k] <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        data_q   <= bus.in_data;
        thr_q    <= bus.threshold;
        off_en_q <= bus.off_spike_en;
        ch_q     <= '0;
      end else if (busy_c) begin
        ch_q <= ch_q + 1'b1;
      end
      if (push) begin
        prev_q[ch_q] <= cur_s;
        wr_ptr       <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (drop)             overflow_q <= 1'b1;
      else if (bus.ovf_clr) overflow_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_ch[wr_ptr]  <= ch_q;
      mem_pol[wr_ptr] <= is_on;
    end
  end

`ifdef DELTA_SCHED_TIMESTAMP_EN
  logic [7:0] frame_cnt, ts_q;
  logic [7:0] mem_ts [FIFO_DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      ts_q      <= '0;
    end else if (accept) begin
      ts_q      <= frame_cnt;
      frame_cnt <= frame_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_ts[wr_ptr] <= ts_q;
  end

  assign bus.ev_ts = fifo_empty ? 8'd0 : mem_ts[rd_ptr];
`else
  assign bus.ev_ts = 8'd0;
`endif

  assign bus.in_ready = in_ready_c;
  assign bus.busy     = busy_c;
  assign bus.ev_valid = !fifo_empty;
  assign bus.ev_ch    = fifo_empty ? '0 : mem_ch[rd_ptr];
  assign bus.ev_pol   = !fifo_empty && mem_pol[rd_ptr];
  assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_delta_scheduler.sv
// tb/tb_delta_scheduler.sv - Self-checking bench for delta_scheduler (table, sequences, random vs model)
module tb_delta_scheduler;
  localparam int NUM_CH     = 4;
  localparam int DW         = 4;
  localparam int FIFO_DEPTH = 4;
`ifdef DELTA_SCHED_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  delta_scheduler_if #(.NUM_CH(NUM_CH), .DW(DW)) bus ();

  delta_scheduler #(.NUM_CH(NUM_CH), .DW(DW), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    int ch;
    int pol;
    int ts;
  } ev_t;

  typedef struct {
    logic [15:0] data;
    int          thr;
    bit          off;
    bit          exp_ev;
    int          exp_ch;
    bit          exp_pol;
  } vec_t;

  int  n_tests, n_fail;
  ev_t mq[$];
  int  m_prev[NUM_CH];
  int  m_data[NUM_CH];
  int  m_thr, m_scan, m_ts, m_fcnt;
  bit  m_off, m_ovf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    for (int k = 0; k < NUM_CH; k++) begin
      m_prev[k] = 0;
      m_data[k] = 0;
    end
    m_thr = 0; m_off = 0; m_ovf = 0; m_scan = -1; m_ts = 0; m_fcnt = 0;
  endtask

  // One clock: drive, compare against the model, advance the model across the edge.
  task automatic step(input logic [15:0] d, input bit v, input int thr, input bit off,
                      input bit rdy, input bit clr);
    bit  pop, full, dropped, on, offe;
    int  k, diff;
    ev_t e;
    bus.in_valid = v; bus.in_data = d; bus.threshold = 4'(thr);
    bus.off_spike_en = off; bus.ev_ready = rdy; bus.ovf_clr = clr;
    #1;
    chk("in_ready", 32'(bus.in_ready), 32'(m_scan < 0));
    chk("busy", 32'(bus.busy), 32'(m_scan >= 0));
    chk("ev_valid", 32'(bus.ev_valid), 32'(mq.size() > 0));
    chk("overflow", 32'(bus.overflow), 32'(m_ovf));
    if (mq.size() > 0) begin
      chk("ev_ch", 32'(bus.ev_ch), mq[0].ch);
      chk("ev_pol", 32'(bus.ev_pol), mq[0].pol);
      chk("ev_ts", 32'(bus.ev_ts), mq[0].ts);
    end
    pop = (mq.size() > 0) && rdy;
    full = (mq.size() == FIFO_DEPTH);
    dropped = 1'b0;
    if (m_scan >= 0) begin
      k = m_scan;
      diff = m_data[k] - m_prev[k];
      on = diff > m_thr;
      offe = m_off && (diff < -m_thr);
      if (on || offe) begin
        if (!full || pop) begin
          e.ch = k; e.pol = on ? 1 : 0; e.ts = m_ts;
          mq.push_back(e);
          m_prev[k] = m_data[k];
        end else begin
          m_ovf = 1'b1;
          dropped = 1'b1;
        end
      end
    end
    if (!dropped && clr) m_ovf = 1'b0;
    if (pop) void'(mq.pop_front());
    if (m_scan >= 0) begin
      m_scan = (m_scan == NUM_CH - 1) ? -1 : m_scan + 1;
    end else if (v) begin
      for (int j = 0; j < NUM_CH; j++) m_data[j] = int'(d[j*DW +: DW]);
      m_thr = thr; m_off = off; m_scan = 0;
      m_ts = TS_EN ? (m_fcnt % 256) : 0;
      m_fcnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit rdy, input bit clr);
    step(16'h0000, 1'b0, 0, 1'b0, rdy, clr);
  endtask

  task automatic send_frame(input logic [15:0] d, input int thr, input bit off, input bit rdy);
    step(d, 1'b1, thr, off, rdy, 1'b0);
    for (int i = 0; i < NUM_CH; i++) step(16'h0000, 1'b0, 0, 1'b0, rdy, 1'b0);
  endtask

  task automatic drain(output int n);
    n = 0;
    for (int i = 0; i < FIFO_DEPTH + 2; i++) begin
      if (bus.ev_valid === 1'b1) n++;
      idle(1'b1, 1'b0);
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  vec_t vecs[10];
  int   n;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_tests = 0; n_fail = 0;
    bus.in_valid = 0; bus.in_data = '0; bus.threshold = '0; bus.off_spike_en = 0;
    bus.ev_ready = 0; bus.ovf_clr = 0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_ev_valid", 32'(bus.ev_valid), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_overflow", 32'(bus.overflow), 0);
    chk("rst_ev_ch", 32'(bus.ev_ch), 0);
    chk("rst_ev_pol", 32'(bus.ev_pol), 0);
    chk("rst_ev_ts", 32'(bus.ev_ts), 0);
    rst_n = 1'b1;

    // Rows run back to back from reset; prev[] carries over between rows.
    vecs[0] = '{16'h0005, 2,  1'b0, 1'b1, 0, 1'b1};
    vecs[1] = '{16'h0005, 2,  1'b0, 1'b0, 0, 1'b0};
    vecs[2] = '{16'h0009, 2,  1'b0, 1'b1, 0, 1'b1};
    vecs[3] = '{16'h0003, 2,  1'b0, 1'b0, 0, 1'b0};
    vecs[4] = '{16'h0003, 2,  1'b1, 1'b1, 0, 1'b0};
    vecs[5] = '{16'h0023, 2,  1'b0, 1'b0, 0, 1'b0};
    vecs[6] = '{16'h0033, 2,  1'b0, 1'b1, 1, 1'b1};
    vecs[7] = '{16'h0F33, 15, 1'b0, 1'b0, 0, 1'b0};
    vecs[8] = '{16'h1033, 0,  1'b0, 1'b1, 3, 1'b1};
    vecs[9] = '{16'h0033, 0,  1'b1, 1'b1, 3, 1'b0};
    for (int i = 0; i < 10; i++) begin
      send_frame(vecs[i].data, vecs[i].thr, vecs[i].off, 1'b0);
      chk("vec_ev_valid", 32'(bus.ev_valid), 32'(vecs[i].exp_ev));
      if (vecs[i].exp_ev) begin
        chk("vec_ev_ch", 32'(bus.ev_ch), vecs[i].exp_ch);
        chk("vec_ev_pol", 32'(bus.ev_pol), 32'(vecs[i].exp_pol));
        chk("vec_ev_ts", 32'(bus.ev_ts), TS_EN ? i : 0);
      end
      drain(n);
      chk("vec_ev_count", n, 32'(vecs[i].exp_ev));
    end

    // Overflow: fill, drop a whole frame, drain in order, clear.
    apply_reset();
    send_frame(16'hFFFF, 0, 1'b1, 1'b0);
    chk("fill_overflow", 32'(bus.overflow), 0);
    send_frame(16'h0000, 0, 1'b1, 1'b0);
    chk("drop_overflow", 32'(bus.overflow), 1);
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      chk("ovf_drain_valid", 32'(bus.ev_valid), 1);
      chk("ovf_drain_ch", 32'(bus.ev_ch), i);
      chk("ovf_drain_pol", 32'(bus.ev_pol), 1);
      idle(1'b1, 1'b0);
    end
    chk("ovf_drained", 32'(bus.ev_valid), 0);
    idle(1'b0, 1'b1);
    chk("ovf_cleared", 32'(bus.overflow), 0);
    send_frame(16'h0000, 0, 1'b1, 1'b0);
    chk("kept_prev_ev", 32'(bus.ev_valid), 1);
    chk("kept_prev_pol", 32'(bus.ev_pol), 0);

    // Full FIFO with ready asserted through a spiking scan: no drop.
    step(16'hFFFF, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < NUM_CH; i++) idle(1'b1, 1'b0);
    chk("full_pop_overflow", 32'(bus.overflow), 0);
    drain(n);
    chk("full_pop_count", n, FIFO_DEPTH);

    // Reset while scanning channel 2.
    step(16'h5555, 1'b1, 0, 1'b1, 1'b0, 1'b0);
    idle(1'b0, 1'b0);
    idle(1'b0, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(bus.in_ready), 1);
    chk("midrst_ev_valid", 32'(bus.ev_valid), 0);
    chk("midrst_busy", 32'(bus.busy), 0);
    chk("midrst_overflow", 32'(bus.overflow), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_frame(16'h5555, 0, 1'b0, 1'b0);
    drain(n);
    chk("midrst_prev_zero", n, NUM_CH);

    // Frame counter wrap: frames 0..254 quiet, 255 and 256 each spike once.
    apply_reset();
    for (int f = 0; f < 255; f++) send_frame(16'h0000, 0, 1'b0, 1'b1);
    send_frame(16'h0001, 0, 1'b0, 1'b0);
    chk("ts_frame255", 32'(bus.ev_ts), TS_EN ? 255 : 0);
    drain(n);
    send_frame(16'h0000, 0, 1'b1, 1'b0);
    chk("ts_frame256_valid", 32'(bus.ev_valid), 1);
    chk("ts_frame256", 32'(bus.ev_ts), 0);
    drain(n);

    // Random traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      step(16'($urandom), 1'($urandom % 2), int'($urandom_range(0, 6)), 1'($urandom % 2),
           ($urandom % 3) != 0, ($urandom % 16) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
